// File: rtl/alu_pkg.sv
// Shared definitions for the UART-driven ALU front end: widths, opcodes, error codes
// and the frame FSM encoding. The ALU itself decodes the same opcode constants.
package alu_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_TX
  } state_e;

  function automatic logic is_valid_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle counter: counts while enabled and flags the last allowed cycle
// so the FSM can abort a stalled frame.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == LAST_CNT);

endmodule

// File: rtl/alu_uart_interface.sv
// Collects A, B, OP bytes from a UART receiver, drives the ALU operands and
// returns the result to the UART transmitter, reporting malformed traffic.
module alu_uart_interface
  import alu_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_operation,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_error,
  output logic [1:0]         o_err_code
);

  state_e state_q, state_d;

  logic [NB_DATA-1:0] dataA_q, dataB_q, txData_q;
  logic [NB_OP-1:0]   operation_q;
  logic               error_q;
  logic [1:0]         errCode_q;

  logic       opValid;
  logic [5:0] opField;
  logic       timerEn, timerClr, timerExpired;
  logic       loadA, loadB, loadOp, loadTx, txStart;
  logic       errSet;
  logic [1:0] errCode;

  // Opcode bits above the operation field must be zero for the byte to be legal
  assign opField = 6'(i_rx_data[NB_OP-1:0]);
  assign opValid = (i_rx_data[NB_DATA-1:NB_OP] == '0) && is_valid_op(opField);

  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_timer (
    .clk_i    (i_clock),
    .rst_ni   (i_reset_n),
    .clear_i  (timerClr),
    .enable_i (timerEn),
    .expired_o(timerExpired)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (i_rx_done) state_d = ST_WAIT_B;
      ST_WAIT_B: begin
        if (i_rx_done)         state_d = ST_WAIT_OP;
        else if (timerExpired) state_d = ST_IDLE;
      end
      ST_WAIT_OP: begin
        if (i_rx_done)         state_d = opValid ? ST_EXEC : ST_IDLE;
        else if (timerExpired) state_d = ST_IDLE;
      end
      ST_EXEC:    state_d = ST_SEND;
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A byte arriving in the same cycle as expiry wins over the timeout
  always_comb begin
    loadA    = 1'b0;
    loadB    = 1'b0;
    loadOp   = 1'b0;
    loadTx   = 1'b0;
    txStart  = 1'b0;
    errSet   = 1'b0;
    errCode  = 2'b00;
    timerEn  = 1'b0;
    case (state_q)
      ST_IDLE:  loadA = i_rx_done;
      ST_WAIT_B: begin
        timerEn = 1'b1;
        loadB   = i_rx_done;
        if (!i_rx_done && timerExpired) begin
          errSet  = 1'b1;
          errCode = ERR_TIMEOUT;
        end
      end
      ST_WAIT_OP: begin
        timerEn = 1'b1;
        loadOp  = i_rx_done && opValid;
        if (i_rx_done && !opValid) begin
          errSet  = 1'b1;
          errCode = ERR_OPCODE;
        end else if (!i_rx_done && timerExpired) begin
          errSet  = 1'b1;
          errCode = ERR_TIMEOUT;
        end
      end
      ST_EXEC, ST_SEND, ST_WAIT_TX: begin
        loadTx  = (state_q == ST_EXEC);
        txStart = (state_q == ST_SEND);
        if (i_rx_done) begin
          errSet  = 1'b1;
          errCode = ERR_OVERRUN;
        end
      end
      default: ;
    endcase
    timerClr = !timerEn || i_rx_done;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dataA_q     <= '0;
      dataB_q     <= '0;
      operation_q <= '0;
      txData_q    <= '0;
      error_q     <= 1'b0;
      errCode_q   <= 2'b00;
    end else begin
      if (loadA)  dataA_q     <= i_rx_data;
      if (loadB)  dataB_q     <= i_rx_data;
      if (loadOp) operation_q <= i_rx_data[NB_OP-1:0];
      if (loadTx) txData_q    <= i_alu_result;
      error_q <= errSet;
      if (errSet) errCode_q <= errCode;
    end
  end

  assign o_data_a    = dataA_q;
  assign o_data_b    = dataB_q;
  assign o_operation = operation_q;
  assign o_tx_data   = txData_q;
  assign o_tx_start  = txStart;
  assign o_error     = error_q;
  assign o_err_code  = errCode_q;

endmodule

// File: doc/alu_uart_interface.md
ALU_UART_INTERFACE -- requirements
Module: alu_uart_interface

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, meaning operand/result/UART byte width.
REQ-002 SHALL have parameter NB_OP, default 6, meaning ALU operation code width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning maximum idle cycles between bytes of one frame.
REQ-004 SHALL have ports: i_clock  in  1  system clock, rising edge.
REQ-005 SHALL have ports: i_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: i_rx_data  in  NB_DATA  byte from UART receiver.
REQ-007 SHALL have ports: i_rx_done  in  1  one-cycle strobe, i_rx_data valid.
REQ-008 SHALL have ports: i_alu_result  in  NB_DATA  combinational ALU result.
REQ-009 SHALL have ports: i_tx_done  in  1  one-cycle strobe, UART transmitter finished byte.
REQ-010 SHALL have ports: o_data_a  out  NB_DATA  ALU operand A (registered).
REQ-011 SHALL have ports: o_data_b  out  NB_DATA  ALU operand B (registered).
REQ-012 SHALL have ports: o_operation  out  NB_OP  ALU operation (registered).
REQ-013 SHALL have ports: o_tx_data  out  NB_DATA  byte to UART transmitter (registered).
REQ-014 SHALL have ports: o_tx_start  out  1  one-cycle pulse, start transmission.
REQ-015 SHALL have ports: o_error  out  1  one-cycle pulse, frame aborted.
REQ-016 SHALL have ports: o_err_code  out  2  cause of last abort: 01 bad opcode, 10 timeout, 11 overrun; held until next abort.

Function
REQ-017 Frame = three bytes in order A, B, OP; FSM states IDLE, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
REQ-018 IDLE: i_rx_done -> o_data_a <= i_rx_data, go WAIT_B.
REQ-019 WAIT_B: i_rx_done -> o_data_b <= i_rx_data, go WAIT_OP.
REQ-020 WAIT_OP: i_rx_done with valid opcode -> o_operation <= i_rx_data[NB_OP-1:0], go EXEC.
REQ-021 Valid opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL, with i_rx_data[7:6] = 00; anything else -> o_error pulse, o_err_code 01, o_operation unchanged, go IDLE.
REQ-022 EXEC (one cycle): o_tx_data <= i_alu_result, go SEND.
REQ-023 SEND (one cycle): o_tx_start = 1, go WAIT_TX; o_tx_start is 0 in every other state.
REQ-024 Latency: OP strobe at cycle N -> o_tx_start high at cycle N+2, o_tx_data valid from N+2.
REQ-025 WAIT_TX: stay until i_tx_done, then go IDLE; no timeout.
REQ-026 Timer counts cycles in WAIT_B/WAIT_OP, cleared on every accepted byte and on entry to IDLE; at TIMEOUT_CYCLES-1 with no i_rx_done -> o_error pulse, o_err_code 10, go IDLE.
REQ-027 i_rx_done in the same cycle as timer expiry: byte accepted, no timeout.
REQ-028 i_rx_done in EXEC, SEND or WAIT_TX: byte dropped, o_error pulse, o_err_code 11, current frame continues.
REQ-029 o_data_a/o_data_b/o_operation hold last accepted values between frames; aborted frames leave the already-captured fields updated.
REQ-030 i_tx_done outside WAIT_TX SHALL be ignored.

Reset
REQ-031 i_reset_n low SHALL immediately clear state to IDLE, timer to 0, all outputs to 0, independent of i_clock.
REQ-032 Reset mid-frame or mid-transmission SHALL discard the frame; first i_rx_done after release is byte A.

Structure
REQ-033 Shared package alu_pkg SHALL hold opcode constants, NB_DATA/NB_OP defaults and FSM state encoding; ALU uses the same opcode constants.
REQ-034 Timeout counter SHALL be sub-module frame_timer (inputs clear, enable; output expired).

Verification (TIMEOUT_CYCLES=16 in bench)
REQ-035 Bytes 0x05, 0x03, 0x20, ALU model -> o_data_a=05, o_data_b=03, o_operation=100000, o_tx_start 2 cycles after OP strobe, o_tx_data=0x08.
REQ-036 Bytes 0x0C, 0x0A, 0x26 -> o_tx_data=0x06; then i_tx_done -> IDLE, next frame 0xF0,0x04,0x03 -> o_tx_data=0xFF (SRA).
REQ-037 Bytes 0x01, 0x02, 0x3F -> o_error pulse, o_err_code=01, no o_tx_start, o_operation unchanged.
REQ-038 Byte 0x01 then silence 16 cycles -> o_error, o_err_code=10; following 0x02,0x02,0x22 -> o_tx_data=0x00.
REQ-039 Extra byte during WAIT_TX -> o_error, o_err_code=11, o_tx_data unchanged, returns IDLE on i_tx_done.
REQ-040 i_reset_n low during WAIT_OP -> outputs 0 asynchronously; after release full frame 0x07,0x01,0x22 -> o_tx_data=0x06.
